time_set_sequencer: RTL and testbench

Sequences manual time and alarm setting for the digital clock. Debounces the five edit buttons and tracks a digit cursor. Maintains a six-digit BCD edit buffer with per-digit legal ranges, then commits the result to either the time counters or the alarm register with a single-cycle load pulse. It sits between the front-panel inputs and the counter/alarm load ports (`pre_hour`/`pre_min`/`pre_sec`, `PE_counter`/`PE_alarm`), and it owns all editing state.

---
 rtl/clock_pkg.sv | 71 +++++++
 rtl/key_debounce.sv | 85 ++++++++
 rtl/time_set_sequencer.sv | 153 +++++++++++++++
 tb/tb_time_set_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time/alarm setting logic: sequencer states, cursor indices,
// digit limits, BCD field offsets and the digit/cursor stepping helpers.
package clock_pkg;

    typedef enum logic [1:0] {StIdle, StLoad, StEdit, StCommit} seq_state_e;

    localparam logic [2:0] CUR_SEC_U  = 3'd0;
    localparam logic [2:0] CUR_SEC_T  = 3'd1;
    localparam logic [2:0] CUR_MIN_U  = 3'd2;
    localparam logic [2:0] CUR_MIN_T  = 3'd3;
    localparam logic [2:0] CUR_HOUR_U = 3'd4;
    localparam logic [2:0] CUR_HOUR_T = 3'd5;

    localparam logic [3:0] MAX_UNITS     = 4'd9;
    localparam logic [3:0] MAX_SEC_MIN_T = 4'd5;
    localparam logic [3:0] MAX_HOUR_T    = 4'd2;
    localparam logic [3:0] MAX_HOUR_U_HI = 4'd3;

    localparam int unsigned SEC_OFS  = 0;
    localparam int unsigned MIN_OFS  = 8;
    localparam int unsigned HOUR_OFS = 16;

    // Largest legal value of the selected digit; hour units depend on the current hour tens.
    function automatic logic [3:0] digit_max(input logic [23:0] t, input logic [2:0] cur);
        logic [3:0] mx;
        mx = 4'd0;
        case (cur)
            CUR_SEC_U, CUR_MIN_U: mx = MAX_UNITS;
            CUR_SEC_T, CUR_MIN_T: mx = MAX_SEC_MIN_T;
            CUR_HOUR_U:           mx = (t[HOUR_OFS+4 +: 4] == MAX_HOUR_T) ? MAX_HOUR_U_HI : MAX_UNITS;
            CUR_HOUR_T:           mx = MAX_HOUR_T;
            default:              mx = 4'd0;
        endcase
        return mx;
    endfunction

    // Increment or decrement one digit with wrap, then clamp hour units if tens became 2.
    function automatic logic [23:0] bcd_step(input logic [23:0] t, input logic [2:0] cur,
                                             input logic inc);
        logic [23:0] r;
        logic [4:0]  idx;
        logic [3:0]  d;
        logic [3:0]  mx;
        r   = t;
        idx = {cur, 2'b00};
        d   = t[idx +: 4];
        mx  = digit_max(t, cur);
        if (inc) begin
            d = (d >= mx) ? 4'd0 : d + 4'd1;
        end else begin
            d = (d == 4'd0 || d > mx) ? mx : d - 4'd1;
        end
        r[idx +: 4] = d;
        if (cur == CUR_HOUR_T && d == MAX_HOUR_T && r[HOUR_OFS +: 4] > MAX_HOUR_U_HI) begin
            r[HOUR_OFS +: 4] = MAX_HOUR_U_HI;
        end
        return r;
    endfunction

    // Alarm sessions never reach the seconds digits.
    function automatic logic [2:0] cursor_step(input logic [2:0] cur, input logic alarm,
                                               input logic inc);
        logic [2:0] lo;
        lo = alarm ? CUR_MIN_U : CUR_SEC_U;
        if (inc) begin
            return (cur >= CUR_HOUR_T) ? lo : cur + 3'd1;
        end
        return (cur <= lo) ? CUR_HOUR_T : cur - 3'd1;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: 2-flop sync, tick-based debounce and one-cycle press pulse.
// Auto-repeat counters exist only when AUTO_REPEAT_EN is defined.
module key_debounce #(
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic raw_i,
    input  logic rpt_en_i,
    output logic press_o
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_MS + 1);

    logic [1:0]      sync_q;
    logic            stable_q;
    logic [CntW-1:0] cnt_q;
    logic            accept;
    logic            rise;

    assign accept = tick_i && (sync_q[1] != stable_q) && (cnt_q == CntW'(DEBOUNCE_MS - 1));
    assign rise   = accept && sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q   <= 2'b00;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], raw_i};
            if (tick_i) begin
                if (sync_q[1] == stable_q) begin
                    cnt_q <= '0;
                end else if (accept) begin
                    stable_q <= sync_q[1];
                    cnt_q    <= '0;
                end else begin
                    cnt_q <= cnt_q + CntW'(1);
                end
            end
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int unsigned RptW = $clog2(REPEAT_DELAY_MS + REPEAT_RATE_MS + 1);

    logic [RptW-1:0] rpt_q;
    logic            rpt_first_q;
    logic            held;
    logic            rpt_fire;

    // Raw level must still be high so a pending release cancels the next repeat.
    assign held     = stable_q && sync_q[1] && rpt_en_i;
    assign rpt_fire = tick_i && held &&
                      (rpt_q == (rpt_first_q ? RptW'(REPEAT_DELAY_MS - 1)
                                             : RptW'(REPEAT_RATE_MS - 1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else if (!held) begin
            rpt_q       <= '0;
            rpt_first_q <= 1'b1;
        end else if (tick_i) begin
            if (rpt_fire) begin
                rpt_q       <= '0;
                rpt_first_q <= 1'b0;
            end else begin
                rpt_q <= rpt_q + RptW'(1);
            end
        end
    end

    assign press_o = rise || rpt_fire;
`else
    logic unused_rpt;
    assign unused_rpt = rpt_en_i ^ (REPEAT_DELAY_MS > REPEAT_RATE_MS);
    assign press_o    = rise;
`endif

endmodule

// File: rtl/time_set_sequencer.sv
// Time/alarm edit sequencer: owns the BCD edit buffer and cursor, commits to the counters or
// alarm with a one-cycle load strobe. AUTO_REPEAT_EN enables up/down auto-repeat.
module time_set_sequencer
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS     = 20,
    parameter int unsigned REPEAT_DELAY_MS = 500,
    parameter int unsigned REPEAT_RATE_MS  = 100
) (
    input  logic        CP,
    input  logic        _CR,
    input  logic        tick_1khz,
    input  logic        adjust,
    input  logic        mode,
    input  logic        left,
    input  logic        right,
    input  logic        up,
    input  logic        down,
    input  logic        apply,
    input  logic [23:0] show_time,
    input  logic [15:0] alarm_time,
    output logic [23:0] edit_time,
    output logic [2:0]  cursor,
    output logic        editing,
    output logic [7:0]  pre_hour,
    output logic [7:0]  pre_min,
    output logic [7:0]  pre_sec,
    output logic        PE_counter,
    output logic        PE_alarm
);

    localparam int unsigned KEY_RIGHT = 0;
    localparam int unsigned KEY_LEFT  = 1;
    localparam int unsigned KEY_DOWN  = 2;
    localparam int unsigned KEY_UP    = 3;
    localparam int unsigned KEY_APPLY = 4;

    seq_state_e  state_q;
    logic [1:0]  adj_sync_q;
    logic [1:0]  mode_sync_q;
    logic        adj_prev_q;
    logic        target_q;
    logic [23:0] edit_q;
    logic [2:0]  cursor_q;
    logic [7:0]  pre_hour_q;
    logic [7:0]  pre_min_q;
    logic [7:0]  pre_sec_q;
    logic        pe_counter_q;
    logic        pe_alarm_q;

    logic        adj_s;
    logic        mode_s;
    logic        abort;
    logic        in_edit;
    logic [4:0]  raw;
    logic [4:0]  rpt_en;
    logic [4:0]  ev;

    assign adj_s   = adj_sync_q[1];
    assign mode_s  = mode_sync_q[1];
    assign abort   = !adj_s || (mode_s != target_q);
    assign in_edit = (state_q == StEdit);
    assign raw     = {apply, up, down, left, right};
    assign rpt_en  = {1'b0, in_edit, in_edit, 2'b00};

    for (genvar i = 0; i < 5; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_MS    (DEBOUNCE_MS),
            .REPEAT_DELAY_MS(REPEAT_DELAY_MS),
            .REPEAT_RATE_MS (REPEAT_RATE_MS)
        ) u_key (
            .clk_i   (CP),
            .rst_ni  (_CR),
            .tick_i  (tick_1khz),
            .raw_i   (raw[i]),
            .rpt_en_i(rpt_en[i]),
            .press_o (ev[i])
        );
    end

    always_ff @(posedge CP or negedge _CR) begin
        if (!_CR) begin
            state_q      <= StIdle;
            adj_sync_q   <= 2'b00;
            mode_sync_q  <= 2'b00;
            adj_prev_q   <= 1'b0;
            target_q     <= 1'b0;
            edit_q       <= '0;
            cursor_q     <= CUR_SEC_U;
            pre_hour_q   <= '0;
            pre_min_q    <= '0;
            pre_sec_q    <= '0;
            pe_counter_q <= 1'b0;
            pe_alarm_q   <= 1'b0;
        end else begin
            adj_sync_q   <= {adj_sync_q[0], adjust};
            mode_sync_q  <= {mode_sync_q[0], mode};
            adj_prev_q   <= adj_s;
            pe_counter_q <= 1'b0;
            pe_alarm_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (adj_s && !adj_prev_q) state_q <= StLoad;
                end
                StLoad: begin
                    if (!adj_s) begin
                        state_q <= StIdle;
                    end else begin
                        target_q <= mode_s;
                        edit_q   <= mode_s ? {alarm_time, 8'h00} : show_time;
                        cursor_q <= mode_s ? CUR_MIN_U : CUR_SEC_U;
                        state_q  <= StEdit;
                    end
                end
                StEdit: begin
                    // Abort outranks every button, including a same-cycle apply.
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (ev[KEY_APPLY]) begin
                        state_q      <= StCommit;
                        pre_hour_q   <= edit_q[HOUR_OFS +: 8];
                        pre_min_q    <= edit_q[MIN_OFS +: 8];
                        pre_sec_q    <= target_q ? 8'h00 : edit_q[SEC_OFS +: 8];
                        pe_counter_q <= !target_q;
                        pe_alarm_q   <= target_q;
                    end else if (ev[KEY_UP]) begin
                        edit_q <= bcd_step(edit_q, cursor_q, 1'b1);
                    end else if (ev[KEY_DOWN]) begin
                        edit_q <= bcd_step(edit_q, cursor_q, 1'b0);
                    end else if (ev[KEY_LEFT]) begin
                        cursor_q <= cursor_step(cursor_q, target_q, 1'b1);
                    end else if (ev[KEY_RIGHT]) begin
                        cursor_q <= cursor_step(cursor_q, target_q, 1'b0);
                    end
                end
                StCommit: begin
                    state_q <= abort ? StIdle : StEdit;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign edit_time  = edit_q;
    assign cursor     = cursor_q;
    assign editing    = (state_q == StEdit) || (state_q == StCommit);
    assign pre_hour   = pre_hour_q;
    assign pre_min    = pre_min_q;
    assign pre_sec    = pre_sec_q;
    assign PE_counter = pe_counter_q;
    assign PE_alarm   = pe_alarm_q;

endmodule

// File: tb/tb_time_set_sequencer.sv
// Scoreboard bench for time_set_sequencer: expected output snapshots are queued by the
// stimulus and popped by a monitor whenever the visible outputs change or a load strobe fires.
module tb_time_set_sequencer;

    logic        CP;
    logic        _CR;
    logic        tick_1khz;
    logic        adjust;
    logic        mode;
    logic [4:0]  btn;
    logic [23:0] show_time;
    logic [15:0] alarm_time;
    logic [23:0] edit_time;
    logic [2:0]  cursor;
    logic        editing;
    logic [7:0]  pre_hour;
    logic [7:0]  pre_min;
    logic [7:0]  pre_sec;
    logic        PE_counter;
    logic        PE_alarm;

    localparam logic [4:0] B_APPLY = 5'b10000;
    localparam logic [4:0] B_UP    = 5'b01000;
    localparam logic [4:0] B_DOWN  = 5'b00100;
    localparam logic [4:0] B_LEFT  = 5'b00010;
    localparam logic [4:0] B_RIGHT = 5'b00001;

    typedef struct packed {
        logic [23:0] et;
        logic [2:0]  cur;
        logic        ed;
        logic        pc;
        logic        pa;
        logic [7:0]  ph;
        logic [7:0]  pm;
        logic [7:0]  ps;
    } obs_t;

    obs_t exp_q[$];
    obs_t m;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   obs_id   = 0;
    logic mon_en   = 1'b0;

    time_set_sequencer #(
        .DEBOUNCE_MS    (20),
        .REPEAT_DELAY_MS(500),
        .REPEAT_RATE_MS (100)
    ) dut (
        .CP        (CP),
        ._CR       (_CR),
        .tick_1khz (tick_1khz),
        .adjust    (adjust),
        .mode      (mode),
        .left      (btn[1]),
        .right     (btn[0]),
        .up        (btn[3]),
        .down      (btn[2]),
        .apply     (btn[4]),
        .show_time (show_time),
        .alarm_time(alarm_time),
        .edit_time (edit_time),
        .cursor    (cursor),
        .editing   (editing),
        .pre_hour  (pre_hour),
        .pre_min   (pre_min),
        .pre_sec   (pre_sec),
        .PE_counter(PE_counter),
        .PE_alarm  (PE_alarm)
    );

    initial begin
        CP = 1'b0;
        forever #5 CP = ~CP;
    end

    // Compressed 1 ms tick: one CP-wide pulse every 4 cycles.
    initial begin
        tick_1khz = 1'b0;
        forever begin
            repeat (3) @(negedge CP);
            tick_1khz = 1'b1;
            @(negedge CP);
            tick_1khz = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    // Monitor: compare on any change of the edit view or on a load strobe.
    initial begin
        obs_t prev;
        obs_t got;
        obs_t e;
        prev = '0;
        forever begin
            @(negedge CP);
            got = {edit_time, cursor, editing, PE_counter, PE_alarm, pre_hour, pre_min, pre_sec};
            if (mon_en && (got.et != prev.et || got.cur != prev.cur || got.ed != prev.ed ||
                           got.pc || got.pa)) begin
                n_checks++;
                obs_id++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL obs%0d unexpected: got t=%h cur=%0d ed=%b PEc=%b PEa=%b pre=%h%h%h, expected none",
                             obs_id, got.et, got.cur, got.ed, got.pc, got.pa, got.ph, got.pm, got.ps);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL obs%0d: got t=%h cur=%0d ed=%b PEc=%b PEa=%b pre=%h%h%h, expected t=%h cur=%0d ed=%b PEc=%b PEa=%b pre=%h%h%h",
                                 obs_id, got.et, got.cur, got.ed, got.pc, got.pa, got.ph, got.pm,
                                 got.ps, e.et, e.cur, e.ed, e.pc, e.pa, e.ph, e.pm, e.ps);
                    end
                end
            end
            prev = got;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic push();
        exp_q.push_back(m);
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) @(posedge tick_1khz);
    endtask

    // Hold buttons well past the debounce window, then release cleanly.
    task automatic press(input logic [4:0] b);
        @(posedge tick_1khz);
        @(negedge CP);
        btn = b;
        wait_ticks(24);
        @(negedge CP);
        btn = '0;
        wait_ticks(24);
    endtask

    task automatic step(input logic [4:0] b, input logic [23:0] et, input logic [2:0] cur);
        m.et  = et;
        m.cur = cur;
        push();
        press(b);
    endtask

    task automatic glitch(input logic [4:0] b);
        @(posedge tick_1khz);
        @(negedge CP);
        btn = b;
        wait_ticks(5);
        @(negedge CP);
        btn = '0;
        wait_ticks(10);
    endtask

    initial begin
        _CR        = 1'b0;
        adjust     = 1'b0;
        mode       = 1'b0;
        btn        = '0;
        show_time  = 24'h123456;
        alarm_time = 16'h0630;
        m          = '0;
        repeat (3) @(negedge CP);
        check("reset_outputs",
              {10'b0, edit_time, cursor, editing, PE_counter, PE_alarm, pre_hour, pre_min, pre_sec},
              64'h0);
        _CR    = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge CP);

        // Clock session load and latency.
        m.et = 24'h123456; m.cur = 3'd0; m.ed = 1'b1;
        push();
        adjust = 1'b1;
        repeat (3) @(negedge CP);
        check("load_not_yet", {63'b0, editing}, 64'h0);
        @(negedge CP);
        check("load_latency", {36'b0, editing, cursor, edit_time}, {36'b0, 1'b1, 3'd0, 24'h123456});
        wait_ticks(4);

        // Cursor wrap, hour wrap and clamp.
        step(B_RIGHT, 24'h123456, 3'd5);
        step(B_RIGHT, 24'h123456, 3'd4);
        step(B_DOWN,  24'h113456, 3'd4);
        step(B_DOWN,  24'h103456, 3'd4);
        step(B_DOWN,  24'h193456, 3'd4);
        step(B_LEFT,  24'h193456, 3'd5);
        step(B_UP,    24'h233456, 3'd5);
        step(B_UP,    24'h033456, 3'd5);
        step(B_DOWN,  24'h233456, 3'd5);
        // Minutes tens wrap both ways.
        step(B_RIGHT, 24'h233456, 3'd4);
        step(B_RIGHT, 24'h233456, 3'd3);
        step(B_UP,    24'h234456, 3'd3);
        step(B_UP,    24'h235456, 3'd3);
        step(B_UP,    24'h230456, 3'd3);
        step(B_DOWN,  24'h235456, 3'd3);
        step(B_RIGHT, 24'h235456, 3'd2);
        step(B_UP,    24'h235556, 3'd2);
        step(B_UP,    24'h235656, 3'd2);
        step(B_UP,    24'h235756, 3'd2);
        step(B_UP,    24'h235856, 3'd2);
        step(B_UP,    24'h235956, 3'd2);
        step(B_RIGHT, 24'h235956, 3'd1);
        step(B_RIGHT, 24'h235956, 3'd0);
        step(B_UP,    24'h235957, 3'd0);
        step(B_UP,    24'h235958, 3'd0);

        // Clock commit: one PE_counter cycle with the buffer on pre_*.
        m.pc = 1'b1; m.ph = 8'h23; m.pm = 8'h59; m.ps = 8'h58;
        push();
        m.pc = 1'b0;
        press(B_APPLY);

        // up beats left in the same cycle.
        step(B_UP | B_LEFT, 24'h235959, 3'd0);

        // adjust drops so the abort lands on the apply event cycle.
        m.ed = 1'b0;
        push();
        @(posedge tick_1khz);
        @(negedge CP);
        btn = B_APPLY;
        wait_ticks(19);
        @(negedge CP);
        @(negedge CP);
        adjust = 1'b0;
        wait_ticks(5);
        @(negedge CP);
        btn = '0;
        wait_ticks(24);

        // Alarm session.
        mode = 1'b1;
        wait_ticks(2);
        m.et = 24'h063000; m.cur = 3'd2; m.ed = 1'b1;
        push();
        @(negedge CP);
        adjust = 1'b1;
        wait_ticks(4);
        step(B_RIGHT, 24'h063000, 3'd5);
        step(B_LEFT,  24'h063000, 3'd2);
        step(B_UP,    24'h063100, 3'd2);
        m.pa = 1'b1; m.ph = 8'h06; m.pm = 8'h31; m.ps = 8'h00;
        push();
        m.pa = 1'b0;
        press(B_APPLY);

        // Mode change away from the session target aborts.
        m.ed = 1'b0;
        push();
        @(negedge CP);
        mode = 1'b0;
        wait_ticks(4);
        @(negedge CP);
        adjust = 1'b0;
        wait_ticks(4);

        // Short glitches and release bounce produce no extra events.
        m.et = 24'h123456; m.cur = 3'd0; m.ed = 1'b1;
        push();
        @(negedge CP);
        adjust = 1'b1;
        wait_ticks(4);
        glitch(B_UP);
        glitch(B_LEFT);
        glitch(B_APPLY);
        m.et = 24'h123457;
        push();
        @(posedge tick_1khz);
        @(negedge CP);
        btn = B_UP;
        wait_ticks(24);
        @(negedge CP);
        btn = '0;
        wait_ticks(5);
        @(negedge CP);
        btn = B_UP;
        wait_ticks(10);
        @(negedge CP);
        btn = '0;
        wait_ticks(24);

        // Reset mid-session clears everything, including pre_*.
        m = '0;
        push();
        @(negedge CP);
        _CR    = 1'b0;
        adjust = 1'b0;
        repeat (3) @(negedge CP);
        _CR = 1'b1;
        repeat (4) @(negedge CP);

`ifdef AUTO_REPEAT_EN
        // 1 s hold of up: one press plus five repeats.
        m.et = 24'h123456; m.cur = 3'd0; m.ed = 1'b1;
        push();
        adjust = 1'b1;
        wait_ticks(4);
        m.et = 24'h123457; push();
        m.et = 24'h123458; push();
        m.et = 24'h123459; push();
        m.et = 24'h123450; push();
        m.et = 24'h123451; push();
        m.et = 24'h123452; push();
        @(posedge tick_1khz);
        @(negedge CP);
        btn = B_UP;
        wait_ticks(1000);
        @(negedge CP);
        btn = '0;
        wait_ticks(30);
`endif

        repeat (20) @(negedge CP);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_outputs: got %0d unobserved, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
